// File: rtl/multdiv_seq.sv
// Iterative multiply/divide unit: one bit per cycle, WIDTH+1 cycle start-to-ready latency,
// double-width product or quotient/remainder, with abort and defined overflow/div-by-zero results.
`timescale 1ns/1ps
module multdiv_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mul,
  input  logic             start_div,
  input  logic             is_signed,
  input  logic             abort,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             result_rdy,
  output logic             exception,
  output logic             busy
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_mag_a;
  logic [WIDTH-1:0]   r_mag_b;
  logic [WIDTH-1:0]   r_dvd;
  logic               r_is_div;
  logic               r_signed;
  logic               r_neg_res;
  logic               r_neg_dvd;
  logic               r_dvz;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_rem_new;
  logic [2*WIDTH-1:0] w_div_nxt;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_lo;
  logic [WIDTH-1:0]   w_res_hi;
  logic               w_res_exc;

  assign busy     = (r_state == S_MUL) || (r_state == S_DIV);
  assign w_accept = (r_state == S_IDLE) && !abort && (start_mul || start_div);
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

  assign w_abs_a = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
  assign w_abs_b = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

  // Shift-add step: low half holds the remaining multiplier bits, high half the partial sum.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
  assign w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};

  // Restoring step: high half is the partial remainder, low half shifts dividend out / quotient in.
  assign w_rem_sh  = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge      = (w_rem_sh >= {1'b0, r_mag_b});
  assign w_rem_new = w_ge ? WIDTH'(w_rem_sh - {1'b0, r_mag_b}) : WIDTH'(w_rem_sh);
  assign w_div_nxt = {w_rem_new, r_acc[WIDTH-2:0], w_ge};

  assign w_prod = r_neg_res ? -w_mul_nxt : w_mul_nxt;
  assign w_quo  = w_div_nxt[WIDTH-1:0];
  assign w_rem  = w_div_nxt[2*WIDTH-1:WIDTH];

  always_comb begin
    w_res_lo  = w_prod[WIDTH-1:0];
    w_res_hi  = w_prod[2*WIDTH-1:WIDTH];
    w_res_exc = 1'b0;
    if (r_is_div) begin
      if (r_dvz) begin
        w_res_lo  = '0;
        w_res_hi  = r_dvd;
        w_res_exc = 1'b1;
      end else if (r_ovf) begin
        w_res_lo  = MIN_VAL;
        w_res_hi  = '0;
        w_res_exc = 1'b1;
      end else begin
        w_res_lo  = r_neg_res ? -w_quo : w_quo;
        w_res_hi  = r_neg_dvd ? -w_rem : w_rem;
      end
    end else if (r_signed) begin
      w_res_exc = (w_res_hi != {WIDTH{w_res_lo[WIDTH-1]}});
    end else begin
      w_res_exc = (w_res_hi != '0);
    end
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mag_a   <= w_abs_a;
      r_mag_b   <= w_abs_b;
      r_dvd     <= operand_a;
      r_is_div  <= !start_mul;
      r_signed  <= is_signed;
      r_neg_res <= is_signed && (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
      r_neg_dvd <= is_signed && operand_a[WIDTH-1];
      r_dvz     <= (operand_b == '0);
      r_ovf     <= is_signed && (operand_a == MIN_VAL) && (operand_b == '1);
      r_acc     <= {{WIDTH{1'b0}}, start_mul ? w_abs_b : w_abs_a};
    end else if (r_state == S_MUL) begin
      r_acc <= w_mul_nxt;
    end else if (r_state == S_DIV) begin
      r_acc <= w_div_nxt;
    end
  end

  // Control FSM with registered result outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      result_lo  <= '0;
      result_hi  <= '0;
      result_rdy <= 1'b0;
      exception  <= 1'b0;
    end else begin
      result_rdy <= 1'b0;
      exception  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!abort) begin
            if (start_mul)      r_state <= S_MUL;
            else if (start_div) r_state <= S_DIV;
          end
        end
        S_MUL, S_DIV: begin
          if (abort) begin
            r_state <= S_IDLE;
          end else if (w_last) begin
            r_state    <= S_DONE;
            result_lo  <= w_res_lo;
            result_hi  <= w_res_hi;
            result_rdy <= 1'b1;
            exception  <= w_res_exc;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/multdiv_seq.md
# multdiv_seq

Parametrised iterative multiply/divide unit for the pipelined core's execute stage, replacing the fixed 32-bit multdiv. It accepts a one-cycle start for multiply or divide, iterates one bit per cycle, and reports a full double-width product or quotient plus remainder with a deterministic latency. The core stalls PC, F/D, D/X, X/M and M/W on `busy` and selects `result_lo` into the X/M latch on `result_rdy`. Beyond the previous unit it adds signed/unsigned mode, a remainder output, `abort` for branch/exception flush, and fully defined overflow and divide-by-zero results.

## Interface
- `WIDTH`, 32: operand and result width (≥4).
- `CNT_W`, $clog2(WIDTH+1): iteration counter width.

- `clock`  in  1  master clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low; one clock; reset is asynchronous and active-low.
- `start_mul`  in  1  start a multiply; sampled only in IDLE.
- `start_div`  in  1  start a divide; sampled only in IDLE.
- `is_signed`  in  1  two's-complement mode when 1; sampled with the start.
- `abort`  in  1  synchronous cancel of the operation in flight.
- `operand_a`  in  WIDTH  multiplicand / dividend; sampled with the start.
- `operand_b`  in  WIDTH  multiplier / divisor; sampled with the start.
- `result_lo`  out  WIDTH  product low half / quotient.
- `result_hi`  out  WIDTH  product high half / remainder.
- `result_rdy`  out  1  one-cycle pulse: results valid.
- `exception`  out  1  valid with `result_rdy`: overflow or divide-by-zero.
- `busy`  out  1  operation in progress; core stall request.

## Operation
- States: IDLE, MUL, DIV, DONE. Reset drives IDLE, counter 0, and all outputs 0.
- IDLE: if `start_mul`, go to MUL; else if `start_div`, go to DIV. Multiply has priority when both are high. On either start, capture the operand magnitudes (absolute values if `is_signed`), the result sign, the dividend sign and the mode.
- MUL: shift-add, one multiplier bit per cycle, 2·WIDTH-bit accumulator, exactly WIDTH cycles, then DONE.
- DIV: restoring divide, one quotient bit per cycle, exactly WIDTH cycles, then DONE.
- DONE: register the sign-corrected results, assert `result_rdy` and `exception` for one cycle, then return to IDLE.
- Signed multiply: the 2·WIDTH product is negated if the operand signs differ. `exception` = `result_hi` is not the sign-extension of `result_lo[WIDTH-1]`.
- Unsigned multiply: `exception` = (`result_hi` != 0).
- Signed divide: the quotient is negated if signs differ. The remainder takes the dividend's sign and |rem| < |divisor|.
- Divide by zero, either mode: `result_lo`=0, `result_hi`=dividend, `exception`=1.
- Signed MIN / −1: `result_lo`=MIN, `result_hi`=0, `exception`=1.
- Outputs hold their last DONE values until the next DONE. `exception` is 0 outside the `result_rdy` cycle.
- `abort` in MUL/DIV/DONE: next state is IDLE; no `result_rdy` pulse; `result_lo`/`result_hi` are not updated. `abort` beats completion.
- `abort` in IDLE: any start that cycle is ignored.
- Start pulses while not IDLE are ignored. There is no queueing.
- Reset asserted mid-operation: immediate return to IDLE, outputs cleared.

## Timing
- Start sampled at edge E. `busy`=1 from after E through edge E+WIDTH (MUL/DIV states).
- DONE is entered at edge E+WIDTH. `result_rdy`=1 in that cycle and `busy`=0 in that cycle. Latency is start-to-ready = WIDTH+1 cycles from the start cycle, independent of operands and exceptions.
- Back-to-back: a new start presented during the DONE cycle is ignored. A start in the following IDLE cycle is accepted, giving a minimum issue interval of WIDTH+2 cycles.
- `busy` is combinationally decoded from state (registered state, no input paths). `result_rdy`, `exception` and results come straight from registers.
- `abort` at edge A: `busy`=0 after A.

## Test plan
- WIDTH=32, signed mul 7 × −3 → after 33 cycles `result_rdy` pulse, `result_lo`=0xFFFFFFEB, `result_hi`=0xFFFFFFFF, `exception`=0; `busy` high for exactly 32 cycles.
- Signed mul 0x00010000 × 0x00010000 → `result_lo`=0, `result_hi`=1, `exception`=1. Unsigned mul 0xFFFFFFFF × 2 → `result_lo`=0xFFFFFFFE, `result_hi`=1, `exception`=1.
- Signed div −7 / 2 → `result_lo`=0xFFFFFFFD, `result_hi`=0xFFFFFFFF. Unsigned div 0xFFFFFFF9 / 2 → `result_lo`=0x7FFFFFFC, `result_hi`=1, `exception`=0.
- Div 5 / 0 → `result_lo`=0, `result_hi`=5, `exception`=1. Signed 0x80000000 / 0xFFFFFFFF → `result_lo`=0x80000000, `result_hi`=0, `exception`=1. Latency 33 cycles in both cases.
- Abort sequence:
  - Start mul 6 × 7; `abort` 10 cycles later → `busy`=0 next cycle, no `result_rdy`, outputs keep prior values.
  - Start div 100 / 7 the next cycle → `result_lo`=14, `result_hi`=2.
  - `start_mul` and `start_div` together → multiply executes.
- Pull `reset` low mid-divide at cycle 15 → all outputs 0 immediately, state IDLE. Release `reset` and start mul 3 × 4 → `result_lo`=12 after 33 cycles.
